ao22_rr_arbiter: RTL and testbench



---
 rtl/ao22_arb_pkg.sv | 25 ++
 rtl/ao22_onehot_mux.sv | 15 +
 rtl/ao22_rr_arbiter.sv | 121 ++++++++++++
 tb/tb_ao22_rr_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ao22_arb_pkg.sv
// Shared definitions for the two-requester AO22 round-robin arbiter.
package ao22_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_G1   = 2'd1,
        ST_G2   = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_1    = 2'b01;
    localparam logic [1:0] GNT_2    = 2'b10;

    localparam int CNT_W = 8;

    // One-hot grant seen by the outside world for a given arbiter state.
    function automatic logic [1:0] gnt_of(input arb_state_t s);
        case (s)
            ST_G1:   return GNT_1;
            ST_G2:   return GNT_2;
            default: return GNT_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ao22_onehot_mux.sv
// WIDTH-bit AND-OR datapath: q = (d1 & s1) | (d2 & s2), selects are one-hot.
module ao22_onehot_mux #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic             s1,
    input  logic             s2,
    output logic [WIDTH-1:0] q
);

    // Both selects low yields zero; the arbiter never raises both.
    assign q = (d1 & {WIDTH{s1}}) | (d2 & {WIDTH{s2}});

endmodule

// File: rtl/ao22_rr_arbiter.sv
// Round-robin burst arbiter driving a shared AO22 mux into a single
// registered output stage. Grants lock for a whole burst (LAST or MAX_BURST).
//
// state | meaning
// IDLE  | no grant; waiting for any requester valid
// G1    | requester 1 owns the datapath
// G2    | requester 2 owns the datapath
module ao22_rr_arbiter
    import ao22_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ1_VALID,
    input  logic [WIDTH-1:0] REQ1_DATA,
    input  logic             REQ1_LAST,
    output logic             REQ1_READY,
    input  logic             REQ2_VALID,
    input  logic [WIDTH-1:0] REQ2_DATA,
    input  logic             REQ2_LAST,
    output logic             REQ2_READY,
    output logic             Q_VALID,
    output logic [WIDTH-1:0] Q_DATA,
    output logic             Q_LAST,
    input  logic             Q_READY,
    output logic [1:0]       GNT
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MAX_BURST - 1);

    arb_state_t       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             ptr_q;        // 0: requester 1 has priority, 1: requester 2
    logic             q_valid_q;
    logic [WIDTH-1:0] q_data_q;
    logic             q_last_q;

    logic             g1, g2;
    logic             out_free;
    logic             accept;
    logic             beat_last;
    logic             burst_end;
    logic             release_beat;
    logic             other_valid;
    logic [WIDTH-1:0] mux_data;

    // Grant decode, ready and release qualification; READY ignores VALID.
    always_comb begin
        g1           = (state_q == ST_G1);
        g2           = (state_q == ST_G2);
        out_free     = !q_valid_q || Q_READY;
        REQ1_READY   = g1 && out_free;
        REQ2_READY   = g2 && out_free;
        accept       = (REQ1_VALID && REQ1_READY) || (REQ2_VALID && REQ2_READY);
        beat_last    = g1 ? REQ1_LAST : REQ2_LAST;
        burst_end    = (cnt_q == LAST_IDX);
        release_beat = accept && (beat_last || burst_end);
        other_valid  = g1 ? REQ2_VALID : REQ1_VALID;
    end

    ao22_onehot_mux #(.WIDTH(WIDTH)) u_mux (
        .d1 (REQ1_DATA),
        .d2 (REQ2_DATA),
        .s1 (g1),
        .s2 (g2),
        .q  (mux_data)
    );

    // Arbiter FSM, burst counter, priority pointer and output register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            ptr_q     <= 1'b0;
            q_valid_q <= 1'b0;
            q_data_q  <= '0;
            q_last_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (REQ1_VALID && REQ2_VALID)
                        state_q <= ptr_q ? ST_G2 : ST_G1;
                    else if (REQ1_VALID)
                        state_q <= ST_G1;
                    else if (REQ2_VALID)
                        state_q <= ST_G2;
                end
                ST_G1, ST_G2: begin
                    if (release_beat) begin
                        cnt_q   <= '0;
                        ptr_q   <= g1;
                        // Hand straight to the other side when it is waiting.
                        if (other_valid)
                            state_q <= g1 ? ST_G2 : ST_G1;
                        else
                            state_q <= ST_IDLE;
                    end else if (accept) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase

            if (accept) begin
                q_valid_q <= 1'b1;
                q_data_q  <= mux_data;
                q_last_q  <= beat_last || burst_end;
            end else if (Q_READY) begin
                q_valid_q <= 1'b0;
            end
        end
    end

    assign Q_VALID = q_valid_q;
    assign Q_DATA  = q_data_q;
    assign Q_LAST  = q_last_q;
    assign GNT     = gnt_of(state_q);

endmodule

// File: tb/tb_ao22_rr_arbiter.sv
// Self-checking bench for ao22_rr_arbiter: directed scenarios plus a random
// phase, all compared cycle by cycle against a burst-level reference model.
module tb_ao22_rr_arbiter;

    localparam int W  = 8;
    localparam int MB = 4;

    logic         CLK = 1'b0;
    logic         RST = 1'b0;
    logic         REQ1_VALID = 1'b0, REQ1_LAST = 1'b0;
    logic [W-1:0] REQ1_DATA = '0;
    logic         REQ2_VALID = 1'b0, REQ2_LAST = 1'b0;
    logic [W-1:0] REQ2_DATA = '0;
    logic         REQ1_READY, REQ2_READY;
    logic         Q_VALID, Q_LAST;
    logic [W-1:0] Q_DATA;
    logic         Q_READY = 1'b0;
    logic [1:0]   GNT;

    ao22_rr_arbiter #(.WIDTH(W), .MAX_BURST(MB)) dut (
        .CLK(CLK), .RST(RST),
        .REQ1_VALID(REQ1_VALID), .REQ1_DATA(REQ1_DATA), .REQ1_LAST(REQ1_LAST), .REQ1_READY(REQ1_READY),
        .REQ2_VALID(REQ2_VALID), .REQ2_DATA(REQ2_DATA), .REQ2_LAST(REQ2_LAST), .REQ2_READY(REQ2_READY),
        .Q_VALID(Q_VALID), .Q_DATA(Q_DATA), .Q_LAST(Q_LAST), .Q_READY(Q_READY),
        .GNT(GNT)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    // producer beat queues: {last, data}
    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] out_log[$];
    logic       gate1 = 1'b1, gate2 = 1'b1, qrdy = 1'b1;

    // reference model: who owns the port, whose turn it is, beats so far
    bit         m_known = 1'b0;
    int         m_owner = 0;      // 0 none, 1 or 2
    int         m_turn  = 1;      // requester favoured on a tie
    int         m_beats = 0;      // beats accepted in current burst
    bit         m_qv    = 1'b0;
    logic [7:0] m_qd    = '0;
    bit         m_ql    = 1'b0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_known = 1'b1;
        m_owner = 0;
        m_turn  = 1;
        m_beats = 0;
        m_qv    = 1'b0;
        m_qd    = '0;
        m_ql    = 1'b0;
    endtask

    task automatic step(input bit rst);
        bit         v1, v2, mr1, mr2, took, rel;
        logic [8:0] b;
        int         other;
        @(negedge CLK);
        RST        = rst;
        v1         = gate1 && (q1.size() > 0);
        v2         = gate2 && (q2.size() > 0);
        REQ1_VALID = v1;
        REQ1_DATA  = v1 ? q1[0][7:0] : 8'($urandom);
        REQ1_LAST  = v1 ? q1[0][8]   : 1'($urandom);
        REQ2_VALID = v2;
        REQ2_DATA  = v2 ? q2[0][7:0] : 8'($urandom);
        REQ2_LAST  = v2 ? q2[0][8]   : 1'($urandom);
        Q_READY    = qrdy;
        #1;
        mr1 = (m_owner == 1) && (!m_qv || qrdy);
        mr2 = (m_owner == 2) && (!m_qv || qrdy);
        if (m_known) begin
            chk("gnt",    32'(GNT), (m_owner == 1) ? 32'h1 : (m_owner == 2) ? 32'h2 : 32'h0);
            chk("ready1", 32'(REQ1_READY), 32'(mr1));
            chk("ready2", 32'(REQ2_READY), 32'(mr2));
            chk("qvalid", 32'(Q_VALID), 32'(m_qv));
            if (m_qv) begin
                chk("qdata", 32'(Q_DATA), 32'(m_qd));
                chk("qlast", 32'(Q_LAST), 32'(m_ql));
            end
        end
        if (!rst && Q_VALID === 1'b1 && qrdy)
            out_log.push_back({Q_LAST, Q_DATA});

        if (rst) begin
            model_reset();
        end else begin
            took = (v1 && mr1) || (v2 && mr2);
            rel  = 1'b0;
            b    = '0;
            if (took) begin
                b   = (v1 && mr1) ? q1.pop_front() : q2.pop_front();
                rel = b[8] || (m_beats + 1 == MB);
                m_qv = 1'b1;
                m_qd = b[7:0];
                m_ql = rel;
            end else if (qrdy) begin
                m_qv = 1'b0;
            end
            if (m_owner == 0) begin
                if (v1 && v2)  m_owner = m_turn;
                else if (v1)   m_owner = 1;
                else if (v2)   m_owner = 2;
            end else if (took) begin
                m_beats++;
                if (rel) begin
                    other   = 3 - m_owner;
                    m_beats = 0;
                    m_turn  = other;
                    m_owner = ((other == 1) ? v1 : v2) ? other : 0;
                end
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0);
    endtask

    task automatic fresh();
        q1.delete();
        q2.delete();
        gate1 = 1'b1;
        gate2 = 1'b1;
        qrdy  = 1'b1;
        step(1'b1);
        out_log.delete();
    endtask

    task automatic check_log(input string tag, input logic [8:0] exp[$]);
        chk({tag, "_len"}, 32'(out_log.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < out_log.size(); i++)
            chk(tag, 32'(out_log[i]), 32'(exp[i]));
    endtask

    initial begin
        logic [8:0] e[$];

        // single burst
        fresh();
        q1 = '{9'h011, 9'h022, 9'h133};
        run(8);
        e = '{9'h011, 9'h022, 9'h133};
        check_log("single", e);

        // contention and fairness, no bubble between bursts
        fresh();
        q1 = '{9'h0A0, 9'h1A1, 9'h0A0, 9'h1A1};
        q2 = '{9'h0B0, 9'h1B1, 9'h0B0, 9'h1B1};
        run(12);
        e = '{9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1, 9'h0A0, 9'h1A1, 9'h0B0, 9'h1B1};
        check_log("fair", e);

        // forced release after MAX_BURST beats
        fresh();
        q2 = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h005, 9'h006};
        q1 = '{9'h0C0, 9'h1C1};
        gate1 = 1'b0;
        step(1'b0);
        gate1 = 1'b1;
        run(14);
        e = '{9'h001, 9'h002, 9'h003, 9'h104, 9'h0C0, 9'h1C1, 9'h005, 9'h006};
        check_log("forced", e);

        // backpressure holds the output beat
        fresh();
        q1 = '{9'h05A, 9'h05B, 9'h15C};
        run(2);
        qrdy = 1'b0;
        run(3);
        chk("bp_hold", 32'(Q_DATA), 32'h5A);
        qrdy = 1'b1;
        run(5);
        e = '{9'h05A, 9'h05B, 9'h15C};
        check_log("bp", e);

        // reset in the middle of a burst
        fresh();
        q1 = '{9'h0D1, 9'h0D2, 9'h0D3, 9'h1D4};
        run(3);
        q1.delete();
        step(1'b1);
        out_log.delete();
        q2 = '{9'h1E0};
        step(1'b0);
        chk("rst_qvalid", 32'(Q_VALID), 32'h0);
        run(4);
        e = '{9'h1E0};
        check_log("rst", e);

        // single-cycle valid in IDLE: grant sticks, nothing accepted
        fresh();
        q1 = '{9'h177};
        step(1'b0);
        gate1 = 1'b0;
        run(3);
        chk("drop_gnt", 32'(GNT), 32'h1);
        gate1 = 1'b1;
        run(4);
        e = '{9'h177};
        check_log("drop", e);

        // random traffic
        fresh();
        for (int c = 0; c < 3000; c++) begin
            while (q1.size() < 3) q1.push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
            while (q2.size() < 3) q2.push_back({1'($urandom_range(0, 3) == 0), 8'($urandom)});
            gate1 = ($urandom_range(0, 3) != 0);
            gate2 = ($urandom_range(0, 3) != 0);
            qrdy  = ($urandom_range(0, 9) < 7);
            step($urandom_range(0, 299) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
